// File: rtl/quad_enc_emulator.sv
// Quadrature encoder emulator: turns signed step commands into A/B/Z edges and a position count.
// Latency: first edge lands exactly per clocks after accept; following edges are per clocks apart.
// Backpressure: cmd_ready is high only while idle; abort ends a running command without an edge.
module quad_enc_emulator #(
    parameter int CNT_W      = 32,
    parameter int STEP_W     = 16,
    parameter int PER_W      = 16,
    parameter int CPR_EDGES  = 8192,
    parameter int MIN_PERIOD = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [STEP_W-1:0] cmd_steps,
    input  logic [PER_W-1:0]        cmd_period,
    input  logic                    abort,
    output logic                    A,
    output logic                    B,
    output logic                    Z,
    output logic signed [CNT_W-1:0] pos_count,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted
);

    localparam int IDX_W = (CPR_EDGES > 1) ? $clog2(CPR_EDGES) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CPR_EDGES - 1);
    localparam logic [PER_W-1:0] PER_MIN = PER_W'(MIN_PERIOD);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  rem_q, rem_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [PER_W-1:0]   timer_q, timer_d;
    logic               dir_q, dir_d;
    logic [1:0]         ab_q, ab_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   pos_q, pos_d;
    logic               z_q, z_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic               accept;
    logic [STEP_W-1:0]  steps_u;
    logic [STEP_W-1:0]  steps_mag;
    logic [PER_W-1:0]   per_cmd;

    // Gray-code phase walk: CW 00->10->11->01, CCW the reverse.
    function automatic logic [1:0] phase_step(input logic [1:0] ab, input logic cw);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = cw ? 2'b10 : 2'b01;
            2'b10:   nxt = cw ? 2'b11 : 2'b00;
            2'b11:   nxt = cw ? 2'b01 : 2'b10;
            default: nxt = cw ? 2'b00 : 2'b11;
        endcase
        return nxt;
    endfunction

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign accept    = cmd_valid & cmd_ready;
    assign steps_u   = $unsigned(cmd_steps);
    // Most-negative step count maps to 2^(STEP_W-1), which still fits unsigned.
    assign steps_mag = steps_u[STEP_W-1] ? (~steps_u + STEP_W'(1)) : steps_u;
    assign per_cmd   = (cmd_period < PER_MIN) ? PER_MIN : cmd_period;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        per_d     = per_q;
        timer_d   = timer_q;
        dir_d     = dir_q;
        ab_d      = ab_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (steps_u == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = steps_mag;
                        dir_d   = ~steps_u[STEP_W-1];
                        per_d   = per_cmd;
                        timer_d = per_cmd - PER_W'(1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (timer_q == '0) begin
                    ab_d    = phase_step(ab_q, dir_q);
                    pos_d   = dir_q ? (pos_q + CNT_W'(1)) : (pos_q - CNT_W'(1));
                    if (dir_q)
                        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
                    else
                        idx_d = (idx_q == '0) ? IDX_MAX : idx_q - IDX_W'(1);
                    rem_d   = rem_q - STEP_W'(1);
                    timer_d = per_q - PER_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - PER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        z_d = (idx_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            per_q     <= '0;
            timer_q   <= '0;
            dir_q     <= 1'b0;
            ab_q      <= 2'b00;
            idx_q     <= '0;
            pos_q     <= '0;
            z_q       <= 1'b1;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            per_q     <= per_d;
            timer_q   <= timer_d;
            dir_q     <= dir_d;
            ab_q      <= ab_d;
            idx_q     <= idx_d;
            pos_q     <= pos_d;
            z_q       <= z_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign A         = ab_q[1];
    assign B         = ab_q[0];
    assign Z         = z_q;
    assign pos_count = $signed(pos_q);
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_quad_enc_emulator.sv
// Directed bench for quad_enc_emulator with a 4-edge revolution so index wrap is reachable.
module tb_quad_enc_emulator;

    logic               clk;
    logic               reset_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [15:0] cmd_steps;
    logic [15:0]        cmd_period;
    logic               abort;
    logic               A, B, Z;
    logic signed [31:0] pos_count;
    logic               busy, done, aborted;

    int n_tests = 0;
    int n_fail  = 0;

    quad_enc_emulator #(
        .CNT_W(32), .STEP_W(16), .PER_W(16), .CPR_EDGES(4), .MIN_PERIOD(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .A(A), .B(B), .Z(Z), .pos_count(pos_count),
        .busy(busy), .done(done), .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent A/B decoder watching the outputs.
    logic [1:0]         dec_prev;
    logic signed [31:0] dec_pos;
    int                 gray_err;
    initial gray_err = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            dec_prev = 2'b00;
            dec_pos  = 0;
        end else begin
            case ({dec_prev, A, B})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: dec_pos = dec_pos + 1;
                4'b0001, 4'b0111, 4'b1110, 4'b1000: dec_pos = dec_pos - 1;
                4'b0000, 4'b0101, 4'b1010, 4'b1111: ;
                default: gray_err = gray_err + 1;
            endcase
            dec_prev = {A, B};
        end
    end

    typedef struct {
        int         steps;
        int         per;
        int         cyc;
        logic [1:0] ab;
        logic       z;
        int         pos;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int steps, input int per);
        cmd_valid  = 1'b1;
        cmd_steps  = 16'(steps);
        cmd_period = 16'(per);
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " A"}, 32'(A), 0);
        check({tag, " B"}, 32'(B), 0);
        check({tag, " Z"}, 32'(Z), 1);
        check({tag, " pos"}, pos_count, 0);
        check({tag, " ready"}, 32'(cmd_ready), 1);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " aborted"}, 32'(aborted), 0);
    endtask

    initial begin
        logic [1:0] e2_ab [4];
        logic [1:0] e3_ab [5];
        logic       e3_z  [5];
        int         n;

        e2_ab = '{2'b10, 2'b11, 2'b01, 2'b00};
        e3_ab = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        e3_z  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        // Applied in order, starting from AB=01, index 3, pos -5.
        tbl[0] = '{0,  5, 0,  2'b01, 1'b0, -5};
        tbl[1] = '{1,  0, 2,  2'b00, 1'b1, -4};
        tbl[2] = '{3,  1, 6,  2'b01, 1'b0, -1};
        tbl[3] = '{-2, 7, 14, 2'b10, 1'b0, -3};
        tbl[4] = '{5,  2, 10, 2'b11, 1'b0, 2};
        tbl[5] = '{-2, 3, 6,  2'b00, 1'b1, 0};
        tbl[6] = '{0,  0, 0,  2'b00, 1'b1, 0};

        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;

        // Reset held for 10 clocks, then released.
        repeat (10) tick();
        check_reset_vals("rst_hold");
        reset_n = 1'b1;
        tick();
        check_reset_vals("rst_rel");

        // +4 steps at period 3: edges at clocks 3,6,9,12.
        send(4, 3);
        for (int c = 1; c <= 12; c++) begin
            tick();
            check("t2 ab", 32'({A, B}), (c / 3 == 0) ? 0 : 32'(e2_ab[c/3-1]));
            check("t2 pos", pos_count, c / 3);
            check("t2 done", 32'(done), (c == 12) ? 1 : 0);
        end
        check("t2 busy", 32'(busy), 0);
        check("t2 z", 32'(Z), 1);
        tick();
        check("t2 done clr", 32'(done), 0);

        // -5 steps at period 2 from reset: index wraps through 0.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        send(-5, 2);
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("t3 ab", 32'({A, B}), (c / 2 == 0) ? 0 : 32'(e3_ab[c/2-1]));
            check("t3 z", 32'(Z), (c / 2 == 0) ? 1 : 32'(e3_z[c/2-1]));
            check("t3 pos", pos_count, -(c / 2));
        end

        // Table of commands, including zero-step and period clamp.
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].steps, tbl[i].per);
            wait_done(n);
            check($sformatf("tbl%0d cycles", i), n, tbl[i].cyc);
            check($sformatf("tbl%0d ab", i), 32'({A, B}), 32'(tbl[i].ab));
            check($sformatf("tbl%0d z", i), 32'(Z), 32'(tbl[i].z));
            check($sformatf("tbl%0d pos", i), pos_count, tbl[i].pos);
            check($sformatf("tbl%0d busy", i), 32'(busy), 0);
            tick();
        end

        // Abort on the 11th timer expiry: edge suppressed, phase held.
        send(100, 4);
        for (int c = 1; c <= 43; c++) begin
            tick();
            if (c == 40) begin
                check("t5 pos10", pos_count, 10);
                check("t5 ab10", 32'({A, B}), 3);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5 aborted", 32'(aborted), 1);
        check("t5 done", 32'(done), 0);
        check("t5 busy", 32'(busy), 0);
        check("t5 ready", 32'(cmd_ready), 1);
        check("t5 pos", pos_count, 10);
        check("t5 ab", 32'({A, B}), 3);
        tick();
        check("t5 aborted clr", 32'(aborted), 0);
        check("t5 pos hold", pos_count, 10);
        check("t5 ab hold", 32'({A, B}), 3);
        check("t5 decoder", dec_pos, pos_count);

        // Abort while idle is ignored; same-cycle accept runs normally.
        abort = 1'b1;
        send(1, 2);
        abort = 1'b0;
        check("idle_abort busy", 32'(busy), 1);
        check("idle_abort aborted", 32'(aborted), 0);
        wait_done(n);
        check("idle_abort cycles", n, 2);
        check("idle_abort ab", 32'({A, B}), 1);
        check("idle_abort pos", pos_count, 11);

        // Reset in the middle of a command.
        tick();
        send(50, 2);
        repeat (5) tick();
        check("midrst pos before", pos_count, 13);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // cmd_valid held high: +2 then -2 back to back.
        cmd_valid  = 1'b1;
        cmd_steps  = 16'sd2;
        cmd_period = 16'd2;
        tick();
        cmd_steps  = -16'sd2;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 2) check("t6 pos1", pos_count, 1);
            if (c == 4) begin
                check("t6 done1", 32'(done), 1);
                check("t6 ready1", 32'(cmd_ready), 1);
                check("t6 pos2", pos_count, 2);
            end
            if (c == 5) begin
                check("t6 accept2", 32'(busy), 1);
                check("t6 done1 clr", 32'(done), 0);
                cmd_valid = 1'b0;
            end
            if (c == 9) begin
                check("t6 done2", 32'(done), 1);
                check("t6 pos", pos_count, 0);
                check("t6 ab", 32'({A, B}), 0);
            end
        end
        tick();
        check("t6 decoder", dec_pos, pos_count);
        check("gray", gray_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
